// File: rtl/pipe_pkg.sv
// Constants and types shared by the fetch stage and the hazard unit of the 16-bit core.
package pipe_pkg;

  typedef logic [15:0] word_t;

  localparam word_t NOP      = 16'h0000;
  localparam int    PC_STEP  = 2;
  localparam word_t RESET_PC = 16'h0000;

  // Instruction field positions: opcode | op1 | op2 | op3
  localparam int OPC_MSB = 15, OPC_LSB = 12;
  localparam int OP1_MSB = 11, OP1_LSB = 8;
  localparam int OP2_MSB = 7,  OP2_LSB = 4;
  localparam int OP3_MSB = 3,  OP3_LSB = 0;

  typedef struct packed {
    word_t instr;
    word_t pc;
    logic  valid;
  } ifid_t;

  function automatic logic [3:0] opcode_of(input word_t instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter flop: reset, hold, sequential increment or direct load.
module pc_register
  import pipe_pkg::*;
#(
  parameter word_t RST_VAL = 16'h0000,
  parameter int    STEP    = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  load,
  input  word_t load_addr,
  output word_t pc,
  output word_t pc_inc
);

  // Modulo-2^16 wrap is intentional; no overflow indication.
  assign pc_inc = pc + word_t'(STEP);

  always_ff @(posedge clk) begin
    if (rst)       pc <= RST_VAL;
    else if (load) pc <= load_addr;
    else if (en)   pc <= pc_inc;
  end

endmodule

// File: rtl/ifid_fetch_stage.sv
// Fetch stage: owns the PC and IF/ID register, honours hazard-unit stalls and branch flushes.
module ifid_fetch_stage
  import pipe_pkg::ifid_t;
#(
  parameter pipe_pkg::word_t RESET_PC = pipe_pkg::RESET_PC,
  parameter int              PC_STEP  = pipe_pkg::PC_STEP,
  parameter pipe_pkg::word_t NOP      = pipe_pkg::NOP,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             IFIDWrite,
  input  logic             flush,
  input  logic [15:0]      targetAddr,
  input  logic [15:0]      imemData,
  output logic [15:0]      imemAddr,
  output logic [15:0]      ifidInstr,
  output logic [15:0]      ifidPC,
  output logic             ifidValid,
  output logic             bubble,
  output logic [CNT_W-1:0] stallCount,
  output logic             protoErr
);

  logic [15:0] pc_inc;
  ifid_t       ifid;

  logic stall, mismatch;
  assign stall    = !flush && !PCWrite && !IFIDWrite;
  assign mismatch = !flush && (PCWrite != IFIDWrite);

  pc_register #(.RST_VAL(RESET_PC), .STEP(PC_STEP)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .en        (PCWrite),
    .load      (flush),
    .load_addr (targetAddr),
    .pc        (imemAddr),
    .pc_inc    (pc_inc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid       <= '{instr: NOP, pc: 16'h0000, valid: 1'b0};
      stallCount <= '0;
      protoErr   <= 1'b0;
    end else begin
      // Flush overrides the stall controls entirely.
      if (flush)          ifid <= '{instr: NOP, pc: 16'h0000, valid: 1'b0};
      else if (IFIDWrite) ifid <= '{instr: imemData, pc: pc_inc, valid: 1'b1};
      if (stall && stallCount != '1) stallCount <= stallCount + CNT_W'(1);
      if (mismatch) protoErr <= 1'b1;
    end
  end

  assign ifidInstr = ifid.instr;
  assign ifidPC    = ifid.pc;
  assign ifidValid = ifid.valid;
  assign bubble    = ifid.valid && !IFIDWrite && !flush;

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Directed test-plan scenarios plus randomized stall/flush/reset traffic checked against a behavioural model.
module tb_ifid_fetch_stage;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, PCWrite, IFIDWrite, flush;
  logic [15:0]      targetAddr, imemData, imemAddr, ifidInstr, ifidPC;
  logic             ifidValid, bubble, protoErr;
  logic [CNT_W-1:0] stallCount;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [15:0] imem(input logic [15:0] a);
    logic [15:0] h;
    if (a == 16'h0000) return 16'h0246;
    if (a == 16'h0002) return 16'h0200;
    h = a * 16'h9E37;
    return h ^ 16'h5A5A;
  endfunction

  assign imemData = imem(imemAddr);

  ifid_fetch_stage #(.RESET_PC(16'h0000), .PC_STEP(2), .NOP(16'h0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .flush(flush),
    .targetAddr(targetAddr), .imemData(imemData), .imemAddr(imemAddr),
    .ifidInstr(ifidInstr), .ifidPC(ifidPC), .ifidValid(ifidValid), .bubble(bubble),
    .stallCount(stallCount), .protoErr(protoErr)
  );

  // Behavioural reference: architectural state updated by the mode rules each edge.
  logic [15:0]      m_pc, m_instr, m_ipc;
  logic             m_valid, m_err;
  logic [CNT_W-1:0] m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 16'h0000; m_instr <= 16'h0000; m_ipc <= 16'h0000;
      m_valid <= 1'b0; m_cnt <= '0; m_err <= 1'b0;
    end else if (flush) begin
      m_pc <= targetAddr; m_instr <= 16'h0000; m_ipc <= 16'h0000; m_valid <= 1'b0;
    end else begin
      if (IFIDWrite) begin
        m_instr <= imem(m_pc); m_ipc <= m_pc + 16'd2; m_valid <= 1'b1;
      end
      if (PCWrite) m_pc <= m_pc + 16'd2;
      if (!PCWrite && !IFIDWrite && m_cnt != {CNT_W{1'b1}}) m_cnt <= m_cnt + 1'b1;
      if (PCWrite != IFIDWrite) m_err <= 1'b1;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("imemAddr", 32'(imemAddr), 32'(m_pc));
      cmp("ifidInstr", 32'(ifidInstr), 32'(m_instr));
      cmp("ifidPC", 32'(ifidPC), 32'(m_ipc));
      cmp("ifidValid", 32'(ifidValid), 32'(m_valid));
      cmp("bubble", 32'(bubble), 32'(m_valid && !IFIDWrite && !flush));
      cmp("stallCount", 32'(stallCount), 32'(m_cnt));
      cmp("protoErr", 32'(protoErr), 32'(m_err));
    end
  end

  task automatic cyc(input logic r, input logic pw, input logic iw, input logic fl, input logic [15:0] tg);
    rst = r; PCWrite = pw; IFIDWrite = iw; flush = fl; targetAddr = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic reset2();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1; flush = 1'b0; targetAddr = 16'h0000;
    reset2();
    cmp("rst_pc", 32'(imemAddr), 32'h0000);
    cmp("rst_valid", 32'(ifidValid), 32'h0);
    cmp("rst_cnt", 32'(stallCount), 32'h0);
    cmp("rst_err", 32'(protoErr), 32'h0);
    cmp("rst_bubble", 32'(bubble), 32'h0);

    // RUN from reset: 1-cycle fetch latency
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    cmp("run1_instr", 32'(ifidInstr), 32'h0246);
    cmp("run1_pc", 32'(ifidPC), 32'h0002);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    cmp("run2_instr", 32'(ifidInstr), 32'h0200);
    cmp("run2_addr", 32'(imemAddr), 32'h0004);

    // One-cycle stall with 0246 held
    reset2();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    PCWrite = 1'b0; IFIDWrite = 1'b0; #1;
    cmp("stall_bubble", 32'(bubble), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    cmp("stall_instr", 32'(ifidInstr), 32'h0246);
    cmp("stall_addr", 32'(imemAddr), 32'h0002);
    cmp("stall_cnt", 32'(stallCount), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    cmp("resume_instr", 32'(ifidInstr), 32'h0200);

    // Flush with stall inputs low
    flush = 1'b1; targetAddr = 16'h0040; PCWrite = 1'b0; IFIDWrite = 1'b0; #1;
    cmp("flush_bubble", 32'(bubble), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040);
    cmp("flush_pc", 32'(imemAddr), 32'h0040);
    cmp("flush_instr", 32'(ifidInstr), 32'h0000);
    cmp("flush_valid", 32'(ifidValid), 32'h0);
    cmp("flush_cnt", 32'(stallCount), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    cmp("target_instr", 32'(ifidInstr), 32'(imem(16'h0040)));

    // Mismatched controls: sticky error
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    cmp("err_set", 32'(protoErr), 32'h1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    cmp("err_sticky", 32'(protoErr), 32'h1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    cmp("err_clr", 32'(protoErr), 32'h0);

    // PC wrap at FFFE
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE);
    cmp("wrap_pre", 32'(imemAddr), 32'hFFFE);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    cmp("wrap_addr", 32'(imemAddr), 32'h0000);
    cmp("wrap_ifidpc", 32'(ifidPC), 32'h0000);

    // Long stall saturates the counter
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    cmp("sat_cnt", 32'(stallCount), 32'(2 ** CNT_W - 1));

    // Reset mid-stall
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cmp("rst_stall_pc", 32'(imemAddr), 32'h0000);
    cmp("rst_stall_instr", 32'(ifidInstr), 32'h0000);
    cmp("rst_stall_ifidpc", 32'(ifidPC), 32'h0000);
    cmp("rst_stall_valid", 32'(ifidValid), 32'h0);
    cmp("rst_stall_cnt", 32'(stallCount), 32'h0);
    cmp("rst_stall_bubble", 32'(bubble), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int m;
      logic r, pw, iw, fl;
      m  = int'($urandom_range(0, 99));
      r  = ($urandom_range(0, 99) < 2);
      fl = ($urandom_range(0, 9) == 0);
      if (m < 55)      begin pw = 1'b1; iw = 1'b1; end
      else if (m < 90) begin pw = 1'b0; iw = 1'b0; end
      else             begin pw = m[0]; iw = !m[0]; end
      cyc(r, pw, iw, fl, 16'($urandom));
    end

    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
